lego_bringup_seq: RTL

Parametrised multi-channel bring-up sequencer for LegoFPGA board tops, generalising the single-port PHY bring-up to N_CH independent channels (SGMII/QSFP MAC ports, DDR4 controllers).
- Gates everything on MMCM lock.
- Per channel: pulses PHY/IP reset, holds the datapath reset through a settle window, then waits for the channel's ready indication.
- A timed-out channel is retried a bounded number of times, then latched as failed.
- Channels are enabled by a mask loaded over a valid/ready control port.

---
 rtl/lego_bringup_pkg.sv | 21 ++
 rtl/lego_bringup_ch.sv | 185 ++++++++++++++++++
 rtl/lego_bringup_seq.sv | 92 +++++++++
 3 files changed

// File: rtl/lego_bringup_pkg.sv
// Shared state encodings and sizing helpers for the LegoFPGA multi-channel bring-up sequencer.
package lego_bringup_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [ST_W-1:0] ST_RST_ASSERT = 3'd1;
    localparam logic [ST_W-1:0] ST_SETTLE     = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT_READY = 3'd3;
    localparam logic [ST_W-1:0] ST_UP         = 3'd4;
    localparam logic [ST_W-1:0] ST_FAIL       = 3'd5;

    function automatic int retry_width(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

    function automatic int filt_width(input int loss_filt);
        return (loss_filt < 2) ? 1 : $clog2(loss_filt);
    endfunction

endpackage

// File: rtl/lego_bringup_ch.sv
// One bring-up channel: reset pulse, settle window, ready wait with bounded retry, UP loss filter.
// LEGO_BRINGUP_ACT_LED_EN adds the per-channel activity LED stretcher.
module lego_bringup_ch
    import lego_bringup_pkg::*;
#(
    parameter int RST_HOLD_CYC = 1250,
    parameter int SETTLE_CYC   = 625,
    parameter int TIMEOUT_CYC  = 1048576,
    parameter int MAX_RETRY    = 3,
    parameter int LOSS_FILT    = 2,
    parameter int CNT_W        = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    input  logic start_edge,
    input  logic enable,
    input  logic ready,
    output logic phy_rst_n,
    output logic ch_rst,
    output logic up,
    output logic fail,
    output logic busy
`ifdef LEGO_BRINGUP_ACT_LED_EN
    ,
    input  logic act_pulse,
    output logic act_led
`endif
);

    localparam int RETRY_W = retry_width(MAX_RETRY);
    localparam int LOSS_W  = filt_width(LOSS_FILT);

    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
    localparam logic [LOSS_W-1:0]  LOSS_LAST   = LOSS_W'(LOSS_FILT - 1);

    logic [ST_W-1:0]    state_r, state_s;
    logic [CNT_W-1:0]   timer_r, timer_s;
    logic [RETRY_W-1:0] retry_r, retry_s;
    logic [LOSS_W-1:0]  loss_r,  loss_s;

    // Next-state logic; lock loss and mask disable override every state.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        retry_s = retry_r;
        loss_s  = loss_r;
        if (!locked || !enable) begin
            state_s = ST_IDLE;
            timer_s = '0;
            retry_s = '0;
            loss_s  = '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_FAIL: begin
                    if (start_edge) begin
                        state_s = ST_RST_ASSERT;
                        timer_s = '0;
                        retry_s = '0;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_RST_ASSERT: begin
                    if (timer_r == HOLD_LAST) begin
                        state_s = ST_SETTLE;
                        timer_s = '0;
                    end else begin
                        timer_s = timer_r + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (timer_r == SETTLE_LAST) begin
                        state_s = ST_WAIT_READY;
                        timer_s = '0;
                    end else begin
                        timer_s = timer_r + CNT_W'(1);
                    end
                end
                ST_WAIT_READY: begin
                    // Ready takes priority over a coincident timeout.
                    if (ready) begin
                        state_s = ST_UP;
                        timer_s = '0;
                        loss_s  = '0;
                    end else if (timer_r == TO_LAST) begin
                        timer_s = '0;
                        if (retry_r < RETRY_MAX) begin
                            state_s = ST_RST_ASSERT;
                            retry_s = retry_r + RETRY_W'(1);
                        end else begin
                            state_s = ST_FAIL;
                        end
                    end else begin
                        timer_s = timer_r + CNT_W'(1);
                    end
                end
                ST_UP: begin
                    if (ready) begin
                        loss_s = '0;
                    end else if (loss_r == LOSS_LAST) begin
                        state_s = ST_RST_ASSERT;
                        timer_s = '0;
                        retry_s = '0;
                        loss_s  = '0;
                    end else begin
                        loss_s = loss_r + LOSS_W'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    timer_s = '0;
                    retry_s = '0;
                    loss_s  = '0;
                end
            endcase
        end
    end

    // State, timer, retry and loss-filter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            timer_r <= '0;
            retry_r <= '0;
            loss_r  <= '0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            retry_r <= retry_s;
            loss_r  <= loss_s;
        end
    end

    // Outputs decode the state register only.
    always_comb begin
        phy_rst_n = 1'b0;
        ch_rst    = 1'b1;
        up        = 1'b0;
        fail      = 1'b0;
        busy      = 1'b0;
        case (state_r)
            ST_RST_ASSERT: busy = 1'b1;
            ST_SETTLE: begin
                phy_rst_n = 1'b1;
                busy      = 1'b1;
            end
            ST_WAIT_READY: begin
                phy_rst_n = 1'b1;
                ch_rst    = 1'b0;
                busy      = 1'b1;
            end
            ST_UP: begin
                phy_rst_n = 1'b1;
                ch_rst    = 1'b0;
                up        = 1'b1;
            end
            ST_FAIL: fail = 1'b1;
            default: phy_rst_n = 1'b0;
        endcase
    end

`ifdef LEGO_BRINGUP_ACT_LED_EN
    logic [22:0] act_cnt_r;

    // Activity stretcher: reloads on any pulse while UP, cleared outside UP.
    always_ff @(posedge clk) begin
        if (rst || (state_r != ST_UP)) begin
            act_cnt_r <= 23'd0;
        end else if (act_pulse) begin
            act_cnt_r <= 23'd4194304;
        end else if (act_cnt_r != 23'd0) begin
            act_cnt_r <= act_cnt_r - 23'd1;
        end else begin
            act_cnt_r <= act_cnt_r;
        end
    end

    assign act_led = (act_cnt_r != 23'd0);
`endif

endmodule

// File: rtl/lego_bringup_seq.sv
// Multi-channel bring-up sequencer top: start-edge detect, enable mask port, N_CH channel FSMs.
// Optional LEGO_BRINGUP_ACT_LED_EN adds act_pulse_i/act_led activity indication.
module lego_bringup_seq
    import lego_bringup_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int RST_HOLD_CYC = 1250,
    parameter int SETTLE_CYC   = 625,
    parameter int TIMEOUT_CYC  = 1048576,
    parameter int MAX_RETRY    = 3,
    parameter int LOSS_FILT    = 2,
    parameter int CNT_W        = 21
) (
    input  logic            clk_125,
    input  logic            sys_rst,
    input  logic            mmcm_locked_i,
    input  logic            start_config,
    input  logic [N_CH-1:0] control_data,
    input  logic            control_valid,
    output logic            control_ready,
    input  logic [N_CH-1:0] ch_ready_i,
    output logic [N_CH-1:0] phy_rst_n,
    output logic [N_CH-1:0] ch_rst,
    output logic [N_CH-1:0] ch_up,
    output logic [N_CH-1:0] ch_fail,
    output logic            all_up
`ifdef LEGO_BRINGUP_ACT_LED_EN
    ,
    input  logic [N_CH-1:0] act_pulse_i,
    output logic [N_CH-1:0] act_led
`endif
);

    logic            start_q_r;
    logic            start_edge_s;
    logic [N_CH-1:0] mask_r;
    logic [N_CH-1:0] busy_s;

    // Start edges seen while unlocked are dropped, not deferred.
    assign start_edge_s  = start_config & ~start_q_r & mmcm_locked_i;
    assign control_ready = mmcm_locked_i & ~sys_rst & ~(|busy_s);
    assign all_up        = (&(ch_up | ~mask_r)) & (|mask_r);

    // Registered copy of start_config for edge detection.
    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            start_q_r <= 1'b0;
        end else begin
            start_q_r <= start_config;
        end
    end

    // Enable mask, loaded on a control handshake.
    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            mask_r <= {N_CH{1'b1}};
        end else if (control_valid && control_ready) begin
            mask_r <= control_data;
        end else begin
            mask_r <= mask_r;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        lego_bringup_ch #(
            .RST_HOLD_CYC (RST_HOLD_CYC),
            .SETTLE_CYC   (SETTLE_CYC),
            .TIMEOUT_CYC  (TIMEOUT_CYC),
            .MAX_RETRY    (MAX_RETRY),
            .LOSS_FILT    (LOSS_FILT),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk        (clk_125),
            .rst        (sys_rst),
            .locked     (mmcm_locked_i),
            .start_edge (start_edge_s),
            .enable     (mask_r[g]),
            .ready      (ch_ready_i[g]),
            .phy_rst_n  (phy_rst_n[g]),
            .ch_rst     (ch_rst[g]),
            .up         (ch_up[g]),
            .fail       (ch_fail[g]),
            .busy       (busy_s[g])
`ifdef LEGO_BRINGUP_ACT_LED_EN
            ,
            .act_pulse  (act_pulse_i[g]),
            .act_led    (act_led[g])
`endif
        );
    end

endmodule
